sent_tx_tick_gen_mc: RTL

SENT_TX_TICK_GEN_MC -- requirements
Module: sent_tx_tick_gen_mc

---
 rtl/sent_tx_tick_gen_mc_if.sv | 25 ++
 rtl/sent_tx_tick_gen_mc.sv | 119 +++++++++++
 2 files changed

// File: rtl/sent_tx_tick_gen_mc_if.sv
// Configuration write bus for sent_tx_tick_gen_mc: a request carrying the target
// channel and divide values, with ready/error feedback from the generator.
interface sent_tx_tick_gen_mc_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
  logic              cfg_wr_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [DIV_W-1:0]  cfg_int_i;
  logic [FRAC_W-1:0] cfg_frac_i;
  logic              cfg_ready_o;
  logic              cfg_err_o;

  modport master (
    output cfg_wr_i, cfg_ch_i, cfg_int_i, cfg_frac_i,
    input  cfg_ready_o, cfg_err_o
  );

  modport slave (
    input  cfg_wr_i, cfg_ch_i, cfg_int_i, cfg_frac_i,
    output cfg_ready_o, cfg_err_o
  );
endinterface

// File: rtl/sent_tx_tick_gen_mc.sv
// Multi-channel fractional tick generator: each channel emits a one-cycle tick every
// int or int+1 cycles, with the fraction dithered through a phase accumulator.
module sent_tx_tick_gen_mc #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int DEF_DIV = 8
) (
  input  logic                clk_tx,
  input  logic                reset_tx,
  input  logic [NUM_CH-1:0]   en_i,
  sent_tx_tick_gen_mc_if.slave cfg,
  output logic [NUM_CH-1:0]   tick_o,
  output logic [NUM_CH-1:0]   tick_clk_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] pendVec;
  logic              chInRange;
  logic              cfgAccept;
  logic              cfgLegal;
  logic              cfgErr_q;

  // A channel with a write still waiting to take effect refuses further writes.
  assign chInRange       = {1'b0, cfg.cfg_ch_i} < (CH_W+1)'(NUM_CH);
  assign cfg.cfg_ready_o = chInRange && !pendVec[cfg.cfg_ch_i];
  assign cfgAccept       = cfg.cfg_wr_i && cfg.cfg_ready_o;
  assign cfgLegal        = cfg.cfg_int_i >= DIV_W'(2);
  assign cfg.cfg_err_o   = cfgErr_q;

  always_ff @(posedge clk_tx) begin
    if (reset_tx) cfgErr_q <= 1'b0;
    else          cfgErr_q <= cfgAccept && !cfgLegal;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [DIV_W-1:0]  actInt_q, actInt_d, shInt_q, shInt_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, lastCnt_q, lastCnt_d, curInt;
    logic [FRAC_W-1:0] actFrac_q, actFrac_d, shFrac_q, shFrac_d;
    logic [FRAC_W-1:0] acc_q, acc_d, curFrac;
    logic [FRAC_W:0]   sum;
    logic              pend_q, pend_d, run_q, run_d;
    logic              tick_q, tick_d, tclk_q, tclk_d;
    logic              wrHere, applyNow, newPeriod;

    // Shadow config moves to active immediately when idle, else only as a tick cycle ends.
    assign wrHere    = cfgAccept && cfgLegal && (cfg.cfg_ch_i == CH_W'(g));
    assign applyNow  = pend_q && (!en_i[g] || (run_q && tick_q));
    assign newPeriod = !run_q || tick_q;
    assign curInt    = applyNow ? shInt_q  : actInt_q;
    assign curFrac   = applyNow ? shFrac_q : actFrac_q;
    assign sum       = {1'b0, acc_q} + {1'b0, curFrac};

    always_comb begin
      actInt_d  = curInt;
      actFrac_d = curFrac;
      pend_d    = pend_q && !applyNow;
      shInt_d   = shInt_q;
      shFrac_d  = shFrac_q;
      run_d     = 1'b0;
      cnt_d     = '0;
      acc_d     = '0;
      lastCnt_d = lastCnt_q;
      tick_d    = 1'b0;
      tclk_d    = 1'b0;
      if (wrHere) begin
        shInt_d  = cfg.cfg_int_i;
        shFrac_d = cfg.cfg_frac_i;
        pend_d   = 1'b1;
      end
      // The period end is stored as P-1 so a period of 2^DIV_W still fits in DIV_W bits.
      if (en_i[g]) begin
        run_d  = 1'b1;
        tclk_d = tclk_q ^ (run_q && tick_q);
        if (newPeriod) begin
          cnt_d     = '0;
          acc_d     = sum[FRAC_W-1:0];
          lastCnt_d = curInt - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          acc_d = acc_q;
        end
        tick_d = (cnt_d == lastCnt_d);
      end
    end

    always_ff @(posedge clk_tx) begin
      if (reset_tx) begin
        actInt_q  <= DIV_W'(DEF_DIV);
        actFrac_q <= '0;
        shInt_q   <= DIV_W'(DEF_DIV);
        shFrac_q  <= '0;
        pend_q    <= 1'b0;
        run_q     <= 1'b0;
        cnt_q     <= '0;
        acc_q     <= '0;
        lastCnt_q <= DIV_W'(DEF_DIV - 1);
        tick_q    <= 1'b0;
        tclk_q    <= 1'b0;
      end else begin
        actInt_q  <= actInt_d;
        actFrac_q <= actFrac_d;
        shInt_q   <= shInt_d;
        shFrac_q  <= shFrac_d;
        pend_q    <= pend_d;
        run_q     <= run_d;
        cnt_q     <= cnt_d;
        acc_q     <= acc_d;
        lastCnt_q <= lastCnt_d;
        tick_q    <= tick_d;
        tclk_q    <= tclk_d;
      end
    end

    assign pendVec[g]    = pend_q;
    assign tick_o[g]     = tick_q;
    assign tick_clk_o[g] = tclk_q;
  end
endmodule
